// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampling 8N1 UART receiver feeding a frame parser
// (addr, len, len+1 payload bytes, XOR checksum). Each payload byte becomes
// a one-cycle write strobe with addr/data valid in the same cycle.
// Optional build macro: UART_FRAME_TIMEOUT_EN. When defined, a partial frame
// left idle for TIMEOUT_BITS bit-times is abandoned and the parser resyncs.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 186,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic [7:0] addr,
  output logic       write,
  output logic       error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {P_ADDR, P_LEN, P_DATA, P_SUM} p_state_t;

  // line synchronizer and edge history
  logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;

  // receiver state
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       rx_byte_reg, rx_byte_next;
  logic             stop_hit_reg, stop_hit_next;
  logic             stop_level_reg, stop_level_next;
  logic             byte_valid_reg, frame_err_reg;

  // parser state
  p_state_t   p_state_reg, p_state_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic       write_reg, write_next;
  logic       error_reg, error_next;
  logic [7:0] checksum_reg, checksum_next;
  logic [8:0] remaining_reg, remaining_next;
  logic       timeout_hit;

  // Two-flop synchronizer on the asynchronous line; the idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  // Receiver next-state: mid-bit sampling driven by a down-counter.
  always_comb begin
    rx_state_next   = rx_state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    rx_byte_next    = rx_byte_reg;
    stop_hit_next   = 1'b0;
    stop_level_next = rxd_sync_reg;
    case (rx_state_reg)
      IDLE: begin
        if (rxd_prev_reg && !rxd_sync_reg) begin
          rx_state_next = START;
          cnt_next      = HALF_LAST;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          if (rxd_sync_reg) begin
            rx_state_next = IDLE;          // glitch, not a real start bit
          end else begin
            rx_state_next = DATA;
            cnt_next      = BIT_LAST;
            bit_idx_next  = 3'd0;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          rx_byte_next = {rxd_sync_reg, rx_byte_reg[7:1]};
          cnt_next     = BIT_LAST;
          if (bit_idx_reg == 3'd7) begin
            rx_state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          // back to IDLE right away so a following start edge is not missed
          stop_hit_next = 1'b1;
          rx_state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  // Receiver registers; the stop-bit verdict is staged one extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg   <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= 3'd0;
      rx_byte_reg    <= 8'h00;
      stop_hit_reg   <= 1'b0;
      stop_level_reg <= 1'b1;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      rx_byte_reg    <= rx_byte_next;
      stop_hit_reg   <= stop_hit_next;
      stop_level_reg <= stop_level_next;
      byte_valid_reg <= stop_hit_reg & stop_level_reg;
      frame_err_reg  <= stop_hit_reg & ~stop_level_reg;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  logic [TO_W-1:0] idle_cnt_reg;

  assign timeout_hit = (idle_cnt_reg == TO_W'(TO_LIMIT));

  // Count idle line time inside a partial frame; restart on every byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_reg <= '0;
    end else if (byte_valid_reg || p_state_reg == P_ADDR || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else if (rx_state_reg == IDLE) begin
      idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Parser next-state: framing error resyncs, then bytes, then timeout.
  always_comb begin
    p_state_next   = p_state_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    write_next     = 1'b0;
    error_next     = error_reg;
    checksum_next  = checksum_reg;
    remaining_next = remaining_reg;
    if (frame_err_reg) begin
      error_next    = 1'b1;
      p_state_next  = P_ADDR;
      checksum_next = 8'h00;
    end else if (byte_valid_reg) begin
      case (p_state_reg)
        P_ADDR: begin
          addr_next     = rx_byte_reg;
          checksum_next = rx_byte_reg;
          p_state_next  = P_LEN;
        end
        P_LEN: begin
          remaining_next = {1'b0, rx_byte_reg} + 9'd1;
          checksum_next  = checksum_reg ^ rx_byte_reg;
          p_state_next   = P_DATA;
        end
        P_DATA: begin
          data_next      = rx_byte_reg;
          write_next     = 1'b1;
          checksum_next  = checksum_reg ^ rx_byte_reg;
          remaining_next = remaining_reg - 9'd1;
          if (remaining_reg == 9'd1) begin
            p_state_next = P_SUM;
          end
        end
        P_SUM: begin
          // writes already went out; a bad checksum is only reported
          if (rx_byte_reg != checksum_reg) begin
            error_next = 1'b1;
          end
          p_state_next = P_ADDR;
        end
        default: p_state_next = P_ADDR;
      endcase
    end else if (timeout_hit) begin
      p_state_next  = P_ADDR;
      checksum_next = 8'h00;
    end
  end

  // Parser registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_reg   <= P_ADDR;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      write_reg     <= 1'b0;
      error_reg     <= 1'b0;
      checksum_reg  <= 8'h00;
      remaining_reg <= 9'd0;
    end else begin
      p_state_reg   <= p_state_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      write_reg     <= write_next;
      error_reg     <= error_next;
      checksum_reg  <= checksum_next;
      remaining_reg <= remaining_next;
    end
  end

  assign data  = data_reg;
  assign addr  = addr_reg;
  assign write = write_reg;
  assign error = error_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: directed vector table, hand-written corner
// sequences (false start, reset mid-frame, idle timeout) and random frames
// checked against a byte-stream reference model.
module tb_uart_frame_rx;

  localparam int CPB = 4;
  localparam int TOB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic [7:0] addr;
  logic       write;
  logic       error;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk  (clk),
    .reset(reset),
    .rxd  (rxd),
    .data (data),
    .addr (addr),
    .write(write),
    .error(error)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] got_q[$];   // {addr,data} seen on write strobes
  logic [15:0] exp_q[$];   // {addr,data} predicted by the model
  logic [7:0]  fbuf[$];    // bytes of the frame the model is assembling
  bit          m_err;
  int          dbl = 0;
  logic        prev_w = 1'b0;

  // capture write strobes and detect strobes longer than one cycle
  always @(negedge clk) begin
    if (write && !reset) got_q.push_back({addr, data});
    if (write && prev_w) dbl <= dbl + 1;
    prev_w <= write;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_hi);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_hi;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic model_reset();
    fbuf.delete();
    exp_q.delete();
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    model_reset();
  endtask

  // Frame = addr, len, len+1 payload bytes, xor of everything before it.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int s;
    logic [7:0] x;
    if (!stop_ok) begin
      m_err = 1'b1;
      fbuf.delete();
      return;
    end
    fbuf.push_back(b);
    s = fbuf.size();
    if (s >= 3 && s <= int'(fbuf[1]) + 3) begin
      exp_q.push_back({fbuf[0], b});
    end else if (s >= 3 && s == int'(fbuf[1]) + 4) begin
      x = 8'h00;
      for (int i = 0; i < s - 1; i++) x = x ^ fbuf[i];
      if (x != b) m_err = 1'b1;
      fbuf.delete();
    end
  endtask

  task automatic compare_model(input string name);
    int n;
    chk({name, " nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s write%0d", name, i), got_q[i], exp_q[i]);
    chk({name, " error"}, error, m_err);
    $display("%s: writes=%0d error=%0d", name, got_q.size(), error);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_writes(input string name, input int n, input logic [47:0] ew);
    logic [15:0] e;
    chk({name, " nwrites"}, got_q.size(), n);
    for (int j = 0; j < n && j < got_q.size(); j++) begin
      e = ew[16*j +: 16];
      chk($sformatf("%s write%0d", name, j), got_q[j], e);
    end
    if (n > 0) begin
      e = ew[16*(n-1) +: 16];
      chk({name, " held"}, {addr, data}, e);
    end
    $display("%s: writes=%0d error=%0d", name, got_q.size(), error);
    got_q.delete();
  endtask

  typedef struct {
    bit          rst;
    int          n;
    logic [63:0] bytes;     // byte i at [8*i +: 8]
    logic [7:0]  stop_low;  // bit i: byte i sent with a low stop bit
    int          nw;
    logic [47:0] ew;        // write j {addr,data} at [16*j +: 16]
    bit          err;
  } vec_t;

  function automatic vec_t mk(bit rst, int n, logic [63:0] bytes, logic [7:0] sl,
                              int nw, logic [47:0] ew, bit err);
    vec_t v;
    v.rst = rst; v.n = n; v.bytes = bytes; v.stop_low = sl;
    v.nw = nw; v.ew = ew; v.err = err;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = mk(1, 4, 64'h92A50037,         8'h00, 1, 48'h37A5,         0);
    vecs[1] = mk(0, 6, 64'h3703_0201_0235,   8'h00, 3, 48'h3503_3502_3501, 0);
    vecs[2] = mk(0, 4, 64'h00810040,         8'h00, 1, 48'h4081,         1);
    vecs[3] = mk(0, 4, 64'h43020041,         8'h00, 1, 48'h4102,         1);
    vecs[4] = mk(1, 1, 64'h37,               8'h01, 0, 48'h0,            1);
    vecs[5] = mk(0, 4, 64'h26110037,         8'h00, 1, 48'h3711,         1);
    vecs[6] = mk(1, 3, 64'hA50037,           8'h04, 0, 48'h0,            1);
    vecs[7] = mk(0, 4, 64'h92A50037,         8'h00, 1, 48'h37A5,         1);
    vecs[8] = mk(1, 5, 64'hA4_3CC3_015A,     8'h00, 2, 48'h5A3C_5AC3,    0);

    // reset values
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset data", data, 8'h00);
    chk("reset addr", addr, 8'h00);
    chk("reset write", write, 1'b0);
    chk("reset error", error, 1'b0);
    $display("reset: data=%h addr=%h write=%0d error=%0d", data, addr, write, error);
    reset = 1'b0;
    model_reset();

    // directed vector table
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst) do_reset();
      got_q.delete();
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].bytes[8*i +: 8], !vecs[v].stop_low[i]);
      idle(16);
      check_writes($sformatf("vec%0d", v), vecs[v].nw, vecs[v].ew);
      chk($sformatf("vec%0d error", v), error, vecs[v].err);
    end

    // one-clock low glitch is a false start; receiver must recover
    do_reset();
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    idle(40);
    check_writes("glitch", 0, 48'h0);
    chk("glitch error", error, 1'b0);
    send_byte(8'h37, 1); send_byte(8'h00, 1); send_byte(8'hA5, 1); send_byte(8'h92, 1);
    idle(16);
    check_writes("after_glitch", 1, 48'h37A5);
    chk("after_glitch error", error, 1'b0);

    // reset mid-frame and mid-byte discards partial state
    do_reset();
    send_byte(8'h37, 1); send_byte(8'h02, 1); send_byte(8'h01, 1);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(8);
    got_q.delete();
    send_byte(8'h37, 1); send_byte(8'h00, 1); send_byte(8'hA5, 1); send_byte(8'h92, 1);
    idle(16);
    check_writes("mid_reset", 1, 48'h37A5);
    chk("mid_reset error", error, 1'b0);

    // partial frame followed by a long idle gap
    do_reset();
    send_byte(8'h37, 1); send_byte(8'h02, 1);
    idle(40);
    send_byte(8'h40, 1); send_byte(8'h00, 1); send_byte(8'h7E, 1); send_byte(8'h3E, 1);
    idle(16);
`ifdef UART_FRAME_TIMEOUT_EN
    check_writes("timeout", 1, 48'h407E);
    chk("timeout error", error, 1'b0);
`else
    check_writes("timeout", 3, 48'h377E_3700_3740);
    chk("timeout error", error, 1'b1);
`endif

    // random frames against the reference model
    do_reset();
    for (int f = 0; f < 16; f++) begin
      logic [7:0] fr[$];
      logic [7:0] cs;
      int len;
      int fe_at;
      len = (f == 7) ? 255 : int'($urandom_range(0, 5));
      fr.push_back(8'($urandom));
      fr.push_back(8'(len));
      for (int i = 0; i <= len; i++) fr.push_back(8'($urandom));
      cs = 8'h00;
      foreach (fr[i]) cs = cs ^ fr[i];
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      fr.push_back(cs);
      fe_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, fr.size() - 1)) : -1;
      for (int i = 0; i < fr.size(); i++) begin
        send_byte(fr[i], i != fe_at);
        model_byte(fr[i], i != fe_at);
        if (i == fe_at) break;
        idle($urandom_range(0, 8));
      end
      idle(12);
      compare_model($sformatf("rand%0d len=%0d fe=%0d", f, len, fe_at));
    end

    chk("write width", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
